// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy watermarks,
// sticky overflow/underflow flags and a peak-occupancy debug register.
module sync_fwft_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pushIn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  popIn,
    input  logic                  clearErrIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  emptyOut,
    output logic                  fullOut,
    output logic                  almostFullOut,
    output logic                  almostEmptyOut,
    output logic [ADDR_WIDTH:0]   countOut,
    output logic                  overflowOut,
    output logic                  underflowOut,
    output logic [ADDR_WIDTH:0]   highWaterOut
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d, high_water_q, high_water_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  push_acc, pop_acc;

    always_comb begin
        push_acc = pushIn & ~fullOut;
        pop_acc  = popIn & ~emptyOut;

        wr_ptr_d = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (push_acc && !pop_acc)
            count_d = count_q + CNT_ONE;
        else if (pop_acc && !push_acc)
            count_d = count_q - CNT_ONE;

        // A set condition beats a simultaneous clear so no error is lost.
        overflow_d  = (pushIn & fullOut)  | (overflow_q  & ~clearErrIn);
        underflow_d = (popIn  & emptyOut) | (underflow_q & ~clearErrIn);

        // Clear restarts tracking from the occupancy we are moving to.
        if (clearErrIn)
            high_water_d = count_d;
        else
            high_water_d = (count_d > high_water_q) ? count_d : high_water_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            high_water_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            high_water_q <= high_water_d;
        end
    end

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && push_acc)
            mem_q[wr_ptr_q] <= dataIn;
    end

    assign emptyOut       = (count_q == '0);
    assign fullOut        = (count_q == DEPTH_C);
    assign almostFullOut  = (count_q >= AF_C);
    assign almostEmptyOut = (count_q <= AE_C);
    assign countOut       = count_q;
    assign overflowOut    = overflow_q;
    assign underflowOut   = underflow_q;
    assign highWaterOut   = high_water_q;
    assign dataOut        = emptyOut ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Scoreboard bench for sync_fwft_fifo: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_sync_fwft_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pushIn = 1'b0, popIn = 1'b0, clearErrIn = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic [DW-1:0] dataOut;
    logic          emptyOut, fullOut, almostFullOut, almostEmptyOut;
    logic [AW:0]   countOut, highWaterOut;
    logic          overflowOut, underflowOut;

    sync_fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .reset(reset), .pushIn(pushIn), .dataIn(dataIn), .popIn(popIn),
        .clearErrIn(clearErrIn), .dataOut(dataOut), .emptyOut(emptyOut), .fullOut(fullOut),
        .almostFullOut(almostFullOut), .almostEmptyOut(almostEmptyOut), .countOut(countOut),
        .overflowOut(overflowOut), .underflowOut(underflowOut), .highWaterOut(highWaterOut)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue plus the sticky debug state.
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_unf, model_ok;
    int            m_hw;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: inputs are stable at the falling edge, so compare the DUT
    // with the model, then advance the model by the coming rising edge.
    always @(negedge clk) begin
        int  sz;
        bit  full, empty;
        sz = exp_q.size();
        if (model_ok) begin
            chk("count",    32'(countOut),       32'(sz));
            chk("empty",    32'(emptyOut),       32'(sz == 0));
            chk("full",     32'(fullOut),        32'(sz == DEPTH));
            chk("afull",    32'(almostFullOut),  32'(sz >= AF));
            chk("aempty",   32'(almostEmptyOut), 32'(sz <= AE));
            chk("dataOut",  32'(dataOut),        (sz == 0) ? 32'h0 : 32'(exp_q[0]));
            chk("overflow", 32'(overflowOut),    32'(m_ovf));
            chk("underflow",32'(underflowOut),   32'(m_unf));
            chk("highWater",32'(highWaterOut),   32'(m_hw));
        end
        if (reset) begin
            exp_q.delete();
            m_ovf = 0; m_unf = 0; m_hw = 0;
            model_ok = 1;
        end else if (model_ok) begin
            full  = (sz == DEPTH);
            empty = (sz == 0);
            if (popIn && !empty)  void'(exp_q.pop_front());
            if (pushIn && !full)  exp_q.push_back(dataIn);
            m_ovf = (pushIn && full)  || (m_ovf && !clearErrIn);
            m_unf = (popIn  && empty) || (m_unf && !clearErrIn);
            sz = exp_q.size();
            m_hw = clearErrIn ? sz : ((sz > m_hw) ? sz : m_hw);
        end
    end

    task automatic cyc(input bit p, input bit po, input logic [DW-1:0] d, input bit c);
        pushIn = p; popIn = po; dataIn = d; clearErrIn = c;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0);
    endtask

    initial begin
        // Reset held for two edges.
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle();

        // Two pushes, two pops.
        cyc(1, 0, 8'h11, 0);
        cyc(1, 0, 8'h22, 0);
        idle();
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'h00, 0);
        idle();

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, DW'(i), 0);
        cyc(1, 0, 8'h99, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'h00, 0);
        idle();

        // Simultaneous push/pop at full, then at empty.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, DW'($urandom), 0);
        cyc(1, 1, 8'hAA, 0);
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 1, 8'h00, 0);
        idle();
        cyc(1, 1, 8'h55, 0);
        idle();
        cyc(0, 1, 8'h00, 0);

        // Wrap stress at occupancy 3, then clear the debug state.
        for (int i = 0; i < 3; i++) cyc(1, 0, DW'(i), 0);
        for (int i = 3; i < 43; i++) cyc(1, 1, DW'(i), 0);
        cyc(0, 0, 8'h00, 1);
        idle();

        // Reset mid-operation with a push pending.
        for (int i = 0; i < 6; i++) cyc(1, 0, DW'(8'hC0 + i), 0);
        reset = 1'b1;
        cyc(1, 0, 8'hEE, 0);
        reset = 1'b0;
        idle();

        // Random traffic with drifting push/pop bias to visit full and empty.
        for (int i = 0; i < 1500; i++) begin
            int pb;
            pb = ((i / 100) % 2 == 0) ? 70 : 30;
            reset = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 99) < pb, $urandom_range(0, 99) < (100 - pb),
                DW'($urandom), $urandom_range(0, 49) == 0);
        end
        reset = 1'b0;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fwft_fifo.md
Name: sync_fwft_fifo

Overview:
- Parameterised single-clock first-word-fall-through FIFO; the buffer stage directly upstream of the pop checker.
- A producer pushes words in. The downstream consumer sees the head word and emptyOut, and pulls words with popIn.
- Provides occupancy count, almost-full/almost-empty watermarks, sticky overflow/underflow error flags and a high-water mark for debug.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default).
- AF_THRESH, 14, almostFullOut asserted when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almostEmptyOut asserted when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pushIn  input  1  push request.
- dataIn  input  DATA_WIDTH  word to push; sampled when a push is accepted.
- popIn  input  1  pop request.
- clearErrIn  input  1  clears overflowOut, underflowOut and highWaterOut.
- dataOut  output  DATA_WIDTH  head word (FWFT).
- emptyOut  output  1  count == 0.
- fullOut  output  1  count == DEPTH.
- almostFullOut  output  1  count >= AF_THRESH.
- almostEmptyOut  output  1  count <= AE_THRESH.
- countOut  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflowOut  output  1  sticky: push attempted while full.
- underflowOut  output  1  sticky: pop attempted while empty.
- highWaterOut  output  ADDR_WIDTH+1  peak occupancy since last reset or clear.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Write/read pointers, count, overflowOut, underflowOut and highWaterOut go to 0.
  - Resulting outputs: emptyOut=1, fullOut=0, almostEmptyOut=1, almostFullOut=(AF_THRESH==0 ? 1 : 0), dataOut=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents and overrides any simultaneous push, pop or clear.
- Acceptance, evaluated against the registered state at the clock edge:
  - pushAcc = pushIn & !fullOut.
  - popAcc = popIn & !emptyOut.
- Push: on pushAcc, mem[wrPtr] <= dataIn and wrPtr increments, wrapping modulo DEPTH.
- Pop: on popAcc, rdPtr increments, wrapping modulo DEPTH.
- Count update:
  - pushAcc only: count+1.
  - popAcc only: count-1.
  - both or neither: unchanged.
- Full FIFO with push and pop in the same cycle: pop is accepted, push is rejected, overflow is set, count becomes DEPTH-1.
- Empty FIFO with push and pop in the same cycle: push is accepted, pop is rejected, underflow is set, count becomes 1.
- dataOut is combinational: emptyOut ? 0 : mem[rdPtr].
  - A word pushed into an empty FIFO appears on dataOut one cycle after the push edge, with emptyOut=0 in the same cycle.
  - After a pop, the next word is visible the following cycle.
- All flags are decoded combinationally from the count register, so they update the cycle after the accepted operation. No flag reflects same-cycle requests.
- overflowOut: set on any edge where pushIn & fullOut.
- underflowOut: set on any edge where popIn & emptyOut.
- Set and clear priority: if a set condition and clearErrIn coincide, set wins and the flag stays 1. Otherwise clearErrIn drives the flag to 0.
- highWaterOut:
  - Updated each edge to max(highWaterOut, next count).
  - clearErrIn loads it with the next count rather than 0.
- Rejected operations never modify memory, pointers or count.
- Pointer wrap must be seamless: contents remain in order across the DEPTH boundary.

Test Plan:
- Reset with reset=1 for 2 cycles -> emptyOut=1, almostEmptyOut=1, countOut=0, dataOut=0, overflowOut=0, underflowOut=0, highWaterOut=0.
- Push 0x11, then 0x22 on consecutive cycles, no pops -> cycle after the first push: emptyOut=0, dataOut=0x11, countOut=1. Pop twice -> dataOut reads 0x22 then 0; emptyOut=1 after the second pop.
- Push 16 words 0x00..0x0F -> fullOut=1 and countOut=16 after the 16th. almostFullOut asserts the cycle countOut reaches 14. A 17th push sets overflowOut=1 with countOut still 16. Pop all 16 -> values 0x00..0x0F in order; highWaterOut=16.
- Full FIFO, pushIn=popIn=1 for one cycle with dataIn=0xAA -> countOut=15, overflowOut=1, 0xAA is never popped. Empty FIFO, pushIn=popIn=1 with dataIn=0x55 -> countOut=1, underflowOut=1, dataOut=0x55 next cycle.
- Wrap stress: 40 cycles of simultaneous push/pop at occupancy 3 with an incrementing pattern -> popped sequence strictly in order, countOut constant at 3. clearErrIn=1 -> both error flags 0 and highWaterOut=3.
- Assert reset while countOut=9 and pushIn=1 -> next cycle countOut=0, emptyOut=1, dataOut=0, push ignored.
